as5402_core: RTL

AS5402_CORE -- requirements
Module: as5402_core

---
 rtl/as5402_pkg.sv | 35 +++
 rtl/as5402_if.sv | 29 ++
 rtl/as5402_alu.sv | 40 ++++
 rtl/as5402_core.sv | 127 ++++++++++++
 4 files changed

// File: rtl/as5402_pkg.sv
// Shared opcode and phase encodings for the AS5402 4-phase accumulator core.
package as5402_pkg;

    typedef enum logic [3:0] {
        OP_LDI  = 4'h0,
        OP_STR  = 4'h1,
        OP_SEC  = 4'h2,
        OP_CLC  = 4'h3,
        OP_JMP  = 4'h4,
        OP_LML  = 4'h5,
        OP_LMH  = 4'h6,
        OP_LDR  = 4'h7,
        OP_ADD  = 4'h8,
        OP_SUB  = 4'h9,
        OP_NAND = 4'hA,
        OP_XOR  = 4'hB,
        OP_SKF  = 4'hC,
        OP_SKZ  = 4'hD,
        OP_SKC  = 4'hE,
        OP_NOP  = 4'hF
    } opcode_e;

    typedef enum logic [3:0] {
        PH_P0 = 4'b0001,
        PH_P1 = 4'b0010,
        PH_P2 = 4'b0100,
        PH_P3 = 4'b1000
    } phase_e;

    // Opcodes that fetch their operand over the bus and therefore pulse rd.
    function automatic logic reads_bus(opcode_e op);
        return op inside {OP_LDR, OP_ADD, OP_SUB, OP_NAND, OP_XOR};
    endfunction

endpackage

// File: rtl/as5402_if.sv
// Bus bundle between the AS5402 core (slave) and its environment (master).
interface as5402_if #(
    parameter int DATA_W = 4,
    parameter int NUM_EF = 2
);
    logic [3:0]          instr;
    logic [DATA_W-1:0]   data_in;
    logic [NUM_EF-1:0]   ef;
    logic [DATA_W-1:0]   data_out;
    logic                data_oe;
    logic [2*DATA_W-1:0] addr_out;
    logic [3:0]          phase;
    logic                wr;
    logic                rd;
    logic                mar_ld;
    logic                jmp;
    logic                carry;
    logic                skip_active;

    modport master (
        output instr, data_in, ef,
        input  data_out, data_oe, addr_out, phase, wr, rd, mar_ld, jmp, carry, skip_active
    );

    modport slave (
        input  instr, data_in, ef,
        output data_out, data_oe, addr_out, phase, wr, rd, mar_ld, jmp, carry, skip_active
    );
endinterface

// File: rtl/as5402_alu.sv
// Combinational datapath: produces next accumulator and carry for the latched opcode.
module as5402_alu
    import as5402_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  opcode_e           op,
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] operand,
    input  logic              carry_in,
    output logic [DATA_W-1:0] result,
    output logic              carry_out
);
    logic [DATA_W:0] sum;

    // Subtraction adds the inverted operand so carry out means "no borrow".
    always_comb begin
        sum       = '0;
        result    = acc;
        carry_out = carry_in;
        case (op)
            OP_LDI, OP_LDR: result = operand;
            OP_ADD: begin
                sum       = {1'b0, acc} + {1'b0, operand} + {{DATA_W{1'b0}}, carry_in};
                result    = sum[DATA_W-1:0];
                carry_out = sum[DATA_W];
            end
            OP_SUB: begin
                sum       = {1'b0, acc} + {1'b0, ~operand} + {{DATA_W{1'b0}}, carry_in};
                result    = sum[DATA_W-1:0];
                carry_out = sum[DATA_W];
            end
            OP_NAND: result = ~(acc & operand);
            OP_XOR:  result = acc ^ operand;
            OP_SEC:  carry_out = 1'b1;
            OP_CLC:  carry_out = 1'b0;
            default: ;
        endcase
    end
endmodule

// File: rtl/as5402_core.sv
// AS5402 sequencer: four one-hot phases per instruction, registered strobes,
// results committed on the edge leaving P2, single-instruction skip.
module as5402_core
    import as5402_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int NUM_EF = 2
) (
    input  logic    clk,
    input  logic    rst,
    as5402_if.slave bus
);
    phase_e            phase_q;
    opcode_e           op_q;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] mar_l_q;
    logic [DATA_W-1:0] mar_h_q;
    logic [DATA_W-1:0] data_out_q;
    logic              carry_q;
    logic              skip_arm_q;
    logic              skip_active_q;
    logic              wr_q;
    logic              oe_q;
    logic              rd_q;
    logic              mar_ld_q;
    logic              jmp_q;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              ef_hit;

    as5402_alu #(.DATA_W(DATA_W)) u_alu (
        .op        (op_q),
        .acc       (acc_q),
        .operand   (bus.data_in),
        .carry_in  (carry_q),
        .result    (alu_result),
        .carry_out (alu_carry)
    );

    // Accumulator values at or beyond NUM_EF select no flag and never skip.
    always_comb begin
        ef_hit = 1'b0;
        for (int i = 0; i < NUM_EF; i++) begin
            if (acc_q == DATA_W'(i)) ef_hit = bus.ef[i];
        end
    end

    // Strobes are registered one edge ahead of the phase they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q       <= PH_P0;
            op_q          <= OP_NOP;
            acc_q         <= '0;
            mar_l_q       <= '0;
            mar_h_q       <= '0;
            data_out_q    <= '0;
            carry_q       <= 1'b0;
            skip_arm_q    <= 1'b0;
            skip_active_q <= 1'b0;
            wr_q          <= 1'b0;
            oe_q          <= 1'b0;
            rd_q          <= 1'b0;
            mar_ld_q      <= 1'b0;
            jmp_q         <= 1'b0;
        end else begin
            case (phase_q)
                PH_P0: begin
                    phase_q <= PH_P1;
                    op_q    <= opcode_e'(bus.instr);
                    rd_q    <= reads_bus(opcode_e'(bus.instr)) && !skip_active_q;
                end
                PH_P1: begin
                    phase_q <= PH_P2;
                    if (op_q == OP_STR && !skip_active_q) begin
                        wr_q       <= 1'b1;
                        oe_q       <= 1'b1;
                        data_out_q <= acc_q;
                    end
                end
                PH_P2: begin
                    phase_q <= PH_P3;
                    rd_q    <= 1'b0;
                    if (!skip_active_q) begin
                        acc_q   <= alu_result;
                        carry_q <= alu_carry;
                        case (op_q)
                            OP_LML: begin
                                mar_l_q  <= acc_q;
                                mar_ld_q <= 1'b1;
                            end
                            OP_LMH: begin
                                mar_h_q  <= acc_q;
                                mar_ld_q <= 1'b1;
                            end
                            OP_JMP:  jmp_q      <= 1'b1;
                            OP_SKF:  skip_arm_q <= ef_hit;
                            OP_SKZ:  skip_arm_q <= (acc_q == '0);
                            OP_SKC:  skip_arm_q <= carry_q;
                            default: ;
                        endcase
                    end
                end
                default: begin
                    phase_q       <= PH_P0;
                    wr_q          <= 1'b0;
                    oe_q          <= 1'b0;
                    mar_ld_q      <= 1'b0;
                    jmp_q         <= 1'b0;
                    data_out_q    <= '0;
                    skip_active_q <= skip_arm_q;
                    skip_arm_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.phase       = phase_q;
    assign bus.data_out    = data_out_q;
    assign bus.data_oe     = oe_q;
    assign bus.addr_out    = {mar_h_q, mar_l_q};
    assign bus.wr          = wr_q;
    assign bus.rd          = rd_q;
    assign bus.mar_ld      = mar_ld_q;
    assign bus.jmp         = jmp_q;
    assign bus.carry       = carry_q;
    assign bus.skip_active = skip_active_q;
endmodule
